// File: rtl/io_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, the transmit FSM encoding and the divisor floor.
package io_uart_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_PARITY = 8;

    localparam int MIN_DIV = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is ignored and
// the read word is presented combinationally at the head.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR window feeding a FIFO
// and a baud-timed 8N1 shifter. Define IO_UART_PARITY_EN for an even parity bit.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 1042
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOWriteData,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    output logic [31:0] IOReadData,
    output logic        TxD
);

`ifdef IO_UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] bit_div_q, bit_div_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 ovf_q, ovf_d;

    logic [1:0]           reg_sel;
    logic                 wr_txdata, wr_status, wr_div;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic [DIV_WIDTH-1:0] eff_div;
    logic                 bit_end, busy;
    logic                 unused_bits;

    assign reg_sel     = IOAddr[3:2];
    assign wr_txdata   = IOWriteEn && (reg_sel == ADDR_TXDATA);
    assign wr_status   = IOWriteEn && (reg_sel == ADDR_STATUS);
    assign wr_div      = IOWriteEn && (reg_sel == ADDR_DIV);
    assign eff_div     = (div_q < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_q;
    assign bit_end     = (baud_q == bit_div_q - 1'b1);
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign unused_bits = ^{IOAddr[1:0], IOWriteData};

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (IOWriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_div) div_d = IOWriteData[DIV_WIDTH-1:0];
        if (wr_txdata && fifo_full) ovf_d = 1'b1;
        else if (wr_status && IOWriteData[STAT_OVF]) ovf_d = 1'b0;
    end

    // Bit length is latched at every bit boundary so divisor writes never stretch a bit in flight.
    always_comb begin
        state_d   = state_q;
        bit_div_d = bit_div_q;
        baud_d    = baud_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        fifo_pop  = 1'b0;
        if (state_q == IDLE) begin
            baud_d = '0;
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                shift_d   = fifo_dout;
                parity_d  = ^fifo_dout;
                bit_div_d = eff_div;
                state_d   = START;
            end
        end else if (bit_end) begin
            baud_d    = '0;
            bit_div_d = eff_div;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
                end
                PARITY: state_d = STOP;
                STOP: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = ^fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            div_q     <= DIV_WIDTH'(DEFAULT_DIV);
            bit_div_q <= DIV_WIDTH'(DEFAULT_DIV);
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_div_q <= bit_div_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        TxD = 1'b1;
        case (state_q)
            START:   TxD = 1'b0;
            DATA:    TxD = shift_q[0];
            PARITY:  TxD = parity_q;
            default: TxD = 1'b1;
        endcase
    end

    always_comb begin
        IOReadData = '0;
        case (reg_sel)
            ADDR_STATUS: begin
                IOReadData[STAT_BUSY]          = busy;
                IOReadData[STAT_FULL]          = fifo_full;
                IOReadData[STAT_EMPTY]         = fifo_empty;
                IOReadData[STAT_OVF]           = ovf_q;
                IOReadData[STAT_CNT_LO +: 4]   = 4'(fifo_count);
                IOReadData[STAT_PARITY]        = PARITY_EN;
            end
            ADDR_DIV: IOReadData = 32'(div_q);
            default:  IOReadData = '0;
        endcase
    end

endmodule
